spi_master_txn_ctrl: RTL

Transaction sequencer for the SPI master: accepts one command at a time (chip-select, length, TX word) and drives the SPI clock generator's enable. It walks chip-select setup, bit shifting and chip-select hold, then returns the RX word on a response handshake. It sits between the register/bus front-end and the SPI clock generator plus pads. It also owns the clock-divider update path so the divider only changes while idle.

---
 rtl/spi_master_pkg.sv | 22 ++
 rtl/spi_master_shreg.sv | 44 ++++
 rtl/spi_master_txn_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and widths for the SPI master transaction sequencer and its shift-register datapath.
package spi_master_pkg;

  localparam int SPI_DW   = 32;
  localparam int SPI_LENW = 5;
  localparam int SPI_DIVW = 8;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    STOP,
    CS_HOLD,
    RESP
  } state_e;

  // Chip-select is driven low in every state between command accept and the response.
  function automatic logic cs_active(input state_e s);
    return (s == CS_SETUP) || (s == SHIFT) || (s == STOP) || (s == CS_HOLD);
  endfunction

endpackage

// File: rtl/spi_master_shreg.sv
// TX/RX shift registers for one SPI transfer: TX is left-justified on load so bit 31 is always the
// next MOSI bit; RX shifts MISO in from the LSB so the result comes out right-aligned.
module spi_master_shreg
  import spi_master_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                load_i,
  input  logic [SPI_DW-1:0]   tx_data_i,
  input  logic [SPI_LENW-1:0] len_i,
  input  logic                shift_i,
  input  logic                sample_i,
  input  logic                sdi_i,
  output logic                sdo_o,
  output logic [SPI_DW-1:0]   rx_data_o
);

  logic [SPI_DW-1:0] tx_q;
  logic [SPI_DW-1:0] rx_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load_i) begin
        tx_q <= tx_data_i << (SPI_LENW'(SPI_DW - 1) - len_i);
      end else if (shift_i) begin
        tx_q <= {tx_q[SPI_DW-2:0], 1'b0};
      end

      if (load_i) begin
        rx_q <= '0;
      end else if (sample_i) begin
        rx_q <= {rx_q[SPI_DW-2:0], sdi_i};
      end
    end
  end

  assign sdo_o     = tx_q[SPI_DW-1];
  assign rx_data_o = rx_q;

endmodule

// File: rtl/spi_master_txn_ctrl.sv
// SPI master transaction sequencer: CS setup, mode-0 bit shifting, CS hold and response handshake,
// plus the clock-divider update path that only lets the divider change while idle.
module spi_master_txn_ctrl
  import spi_master_pkg::*;
#(
  parameter int CS_NUM       = 4,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2,
  localparam int CSW = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CSW-1:0]      cmd_csid,
  input  logic [SPI_LENW-1:0] cmd_len,
  input  logic [SPI_DW-1:0]   cmd_tx_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SPI_DW-1:0]   rsp_rx_data,
  output logic                rsp_abort,
  input  logic                abort,
  input  logic [SPI_DIVW-1:0] cfg_div,
  input  logic                cfg_div_wr,
  output logic [SPI_DIVW-1:0] clk_div,
  output logic                clk_div_valid,
  output logic                clk_en,
  input  logic                spi_clk_i,
  input  logic                spi_rise,
  input  logic                spi_fall,
  output logic                sdo,
  input  logic                sdi,
  output logic [CS_NUM-1:0]   cs_n
);

  localparam int CYC_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int CYCW    = $clog2(CYC_MAX + 1);
  localparam int BCW     = SPI_LENW + 1;

  state_e              state_q, state_d;
  logic [CYCW-1:0]     cyc_q, cyc_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CSW-1:0]      csid_q, csid_d;
  logic [SPI_LENW-1:0] len_q, len_d;
  logic                clk_en_q, clk_en_d;
  logic                abort_q, abort_d;
  logic [CS_NUM-1:0]   cs_n_q, cs_n_d;
  logic [SPI_DIVW-1:0] clk_div_q, clk_div_d;
  logic                clk_div_valid_q, clk_div_valid_d;
  logic [SPI_DIVW-1:0] pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;

  logic              sh_load, sh_shift, sh_sample, sh_sdo;
  logic [BCW-1:0]    last_cnt;
  logic              rsp_hs, div_apply;

  assign last_cnt = {1'b0, len_q} + BCW'(1);
  assign rsp_hs   = (state_q == RESP) && rsp_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_cnt_d = bit_cnt_q;
    csid_d    = csid_q;
    len_d     = len_q;
    clk_en_d  = clk_en_q;
    abort_d   = abort_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_sample = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          sh_load   = 1'b1;
          bit_cnt_d = '0;
          cyc_d     = '0;
          csid_d    = cmd_csid;
          len_d     = cmd_len;
          abort_d   = 1'b0;
          state_d   = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (abort) begin
          state_d = STOP;
        end else if (cyc_q == CYCW'(CS_SETUP_CYC - 1)) begin
          clk_en_d = 1'b1;
          state_d  = SHIFT;
        end else begin
          cyc_d = cyc_q + CYCW'(1);
        end
      end
      SHIFT: begin
        if (spi_rise) begin
          sh_sample = 1'b1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
        // A final fall beats a concurrent abort: the transfer has already completed.
        if (spi_fall && (bit_cnt_q == last_cnt)) begin
          clk_en_d = 1'b0;
          cyc_d    = '0;
          state_d  = CS_HOLD;
        end else begin
          sh_shift = spi_fall && (bit_cnt_q <= {1'b0, len_q});
          if (abort) begin
            clk_en_d = 1'b0;
            state_d  = STOP;
          end
        end
      end
      STOP: begin
        clk_en_d = 1'b0;
        if (!spi_clk_i && !spi_rise && !spi_fall) begin
          abort_d = 1'b1;
          cyc_d   = '0;
          state_d = CS_HOLD;
        end
      end
      CS_HOLD: begin
        if (cyc_q == CYCW'(CS_HOLD_CYC - 1)) begin
          state_d = RESP;
        end else begin
          cyc_d = cyc_q + CYCW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cs_n_d = cs_active(state_d) ? ~(CS_NUM'(1) << csid_d) : '1;
  end

  // A write on the IDLE re-entry edge is applied directly, so it overrides any pending value.
  always_comb begin
    div_apply       = (cfg_div_wr && (state_q == IDLE)) || (rsp_hs && (cfg_div_wr || pend_vld_q));
    clk_div_d       = clk_div_q;
    clk_div_valid_d = div_apply;
    pend_d          = pend_q;
    pend_vld_d      = pend_vld_q;
    if (div_apply) begin
      clk_div_d  = cfg_div_wr ? cfg_div : pend_q;
      pend_vld_d = 1'b0;
    end else if (cfg_div_wr) begin
      pend_d     = cfg_div;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      cyc_q           <= '0;
      bit_cnt_q       <= '0;
      csid_q          <= '0;
      len_q           <= '0;
      clk_en_q        <= 1'b0;
      abort_q         <= 1'b0;
      cs_n_q          <= '1;
      clk_div_q       <= '0;
      clk_div_valid_q <= 1'b0;
      pend_q          <= '0;
      pend_vld_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cyc_q           <= cyc_d;
      bit_cnt_q       <= bit_cnt_d;
      csid_q          <= csid_d;
      len_q           <= len_d;
      clk_en_q        <= clk_en_d;
      abort_q         <= abort_d;
      cs_n_q          <= cs_n_d;
      clk_div_q       <= clk_div_d;
      clk_div_valid_q <= clk_div_valid_d;
      pend_q          <= pend_d;
      pend_vld_q      <= pend_vld_d;
    end
  end

  spi_master_shreg u_shreg (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (sh_load),
    .tx_data_i (cmd_tx_data),
    .len_i     (cmd_len),
    .shift_i   (sh_shift),
    .sample_i  (sh_sample),
    .sdi_i     (sdi),
    .sdo_o     (sh_sdo),
    .rx_data_o (rsp_rx_data)
  );

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign rsp_abort     = abort_q;
  assign clk_en        = clk_en_q;
  assign cs_n          = cs_n_q;
  assign clk_div       = clk_div_q;
  assign clk_div_valid = clk_div_valid_q;
  assign sdo           = cs_active(state_q) & sh_sdo;

endmodule
